// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter (ALU path A, load path B) feeding the single RegisterFile write port.
// Round-robin by default; define WB_FIXED_PRIO_EN to make the load path B always win conflicts.
module regfile_wb_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int DROP_R0 = 1,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          RegWrite,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData,
    output logic [CW-1:0] conflict_cnt
);

    logic          w_accept_a;
    logic          w_accept_b;
    logic          w_both_valid;
    logic          w_drop;
    logic [AW-1:0] w_sel_reg;
    logic [DW-1:0] w_sel_data;

    logic          r_reg_write;
    logic [AW-1:0] r_write_reg;
    logic [DW-1:0] r_write_data;
    logic [CW-1:0] r_conflict_cnt;

    assign w_both_valid = a_valid & b_valid;

`ifdef WB_FIXED_PRIO_EN
    // Load path has absolute priority; A only gets the port when B is idle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !freeze) begin
            b_ready = b_valid;
            a_ready = a_valid & ~b_valid;
        end
    end
`else
    logic r_last_b;

    // On a conflict the requester that did not win last time gets the port.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !freeze) begin
            if (w_both_valid) begin
                a_ready = r_last_b;
                b_ready = ~r_last_b;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // Reset to "B won last" so A takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (w_accept_a) begin
            r_last_b <= 1'b0;
        end else if (w_accept_b) begin
            r_last_b <= 1'b1;
        end
    end
`endif

    assign w_accept_a = a_valid & a_ready;
    assign w_accept_b = b_valid & b_ready;
    assign w_sel_reg  = w_accept_a ? a_reg  : b_reg;
    assign w_sel_data = w_accept_a ? a_data : b_data;
    assign w_drop     = (DROP_R0 != 0) && (w_sel_reg == '0);

    // A write to r0 still completes the handshake but never reaches the RegisterFile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_accept_a || w_accept_b) begin
            r_reg_write  <= ~w_drop;
            r_write_reg  <= w_sel_reg;
            r_write_data <= w_sel_data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_both_valid && !freeze && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CW'(1);
        end
    end

    assign RegWrite     = r_reg_write;
    assign WriteReg     = r_write_reg;
    assign WriteData    = r_write_data;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [15:0] conflict_cnt;

    logic        s_a_ready;
    logic        s_b_ready;
    logic        s_reg_write;
    logic [4:0]  s_write_reg;
    logic [31:0] s_write_data;
    logic [3:0]  s_conflict_cnt;

    int checks;
    int failures;

    // Model state: who won last (1=A, 2=B), pending write and counters.
    int          m_last;
    bit          m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          m_cnt;
    int          m_cnt_s;
    int          last_grant;

    regfile_wb_arbiter #(.DW(32), .AW(5), .DROP_R0(1), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.DW(32), .AW(5), .DROP_R0(1), .CW(4)) u_dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(s_b_ready),
        .RegWrite(s_reg_write), .WriteReg(s_write_reg), .WriteData(s_write_data),
        .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which requester the rules say gets the port right now (0 none, 1 A, 2 B).
    function automatic int exp_grant();
        if (rst || freeze) return 0;
        if (a_valid && b_valid) begin
`ifdef WB_FIXED_PRIO_EN
            return 2;
`else
            return (m_last == 2) ? 1 : 2;
`endif
        end
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    function automatic int observed_grant();
        if (a_ready && !b_ready) return 1;
        if (b_ready && !a_ready) return 2;
        if (a_ready && b_ready) return 3;
        return 0;
    endfunction

    // Advance one clock and apply the transaction-level effect of that edge to the model.
    task automatic tick();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (rst) begin
            m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
            m_cnt = 0; m_cnt_s = 0; m_last = 2;
        end else begin
            if (a_valid && b_valid && !freeze) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 15) m_cnt_s++;
            end
            m_rw = 1'b0;
            if (g == 1) begin
                m_wreg = a_reg; m_wdata = a_data; m_rw = (a_reg != 0); m_last = 1;
            end else if (g == 2) begin
                m_wreg = b_reg; m_wdata = b_data; m_rw = (b_reg != 0); m_last = 2;
            end
        end
        last_grant = g;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; freeze = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0;
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hA5A5_0001; b_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready got a=%b b=%b exp a=0 b=0", a_ready, b_ready);
            end
            tick();
            checks++;
            if (RegWrite !== 1'b0 || conflict_cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset_outputs got RegWrite=%b cnt=%0d exp 0/0", RegWrite, conflict_cnt);
            end
        end
        rst = 1'b0;
        #2;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant got a_ready=%b exp=1", a_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL reset_first_write got %b/%0d/%h exp 1/1/a5a50001", RegWrite, WriteReg, WriteData);
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h8765_4321; b_valid = 1'b0;
        #2;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL a_only_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'h8765_4321) begin
            failures++;
            $display("FAIL a_only_write got %b/%0d/%h exp 1/3/87654321", RegWrite, WriteReg, WriteData);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd3 || WriteData !== 32'h8765_4321) begin
            failures++;
            $display("FAIL a_only_idle got %b/%0d/%h exp 0/3/87654321", RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_back_to_back();
        int exp_g;
        int got_g;
        do_reset();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1234_5678;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h1234_abcd;
        for (int i = 0; i < 4; i++) begin
            #2;
`ifdef WB_FIXED_PRIO_EN
            exp_g = 2;
`else
            exp_g = (i % 2 == 0) ? 1 : 2;
`endif
            got_g = observed_grant();
            checks++;
            if (got_g !== exp_g) begin
                failures++;
                $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", i, got_g, exp_g);
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 16'd4) begin
            failures++;
            $display("FAIL b2b_conflict_cnt got=%0d exp=4", conflict_cnt);
        end
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd2 || WriteData !== 32'h1234_abcd) begin
            failures++;
            $display("FAIL b2b_last_write got %b/%0d/%h exp 1/2/1234abcd", RegWrite, WriteReg, WriteData);
        end
        tick();
    endtask

    task automatic test_drop_r0();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hDEAD_0000; b_valid = 1'b0;
        #2;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_ready got a_ready=%b exp=1", a_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL r0_no_write got RegWrite=%b exp=0", RegWrite);
        end
        a_reg = 5'd7; a_data = 32'h0000_0007;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h0000_0009;
        #2;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL r0_next_grant got a=%b b=%b exp a=0 b=1", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'h0000_0009) begin
            failures++;
            $display("FAIL r0_next_write got %b/%0d/%h exp 1/9/00000009", RegWrite, WriteReg, WriteData);
        end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h0000_0066;
        tick();
        freeze = 1'b1;
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h0000_0044;
        b_reg = 5'd8; b_data = 32'h0000_0088;
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd6) begin
            failures++;
            $display("FAIL freeze_pending_write got %b/%0d exp 1/6", RegWrite, WriteReg);
        end
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL freeze_ready[%0d] got a=%b b=%b exp 0/0", i, a_ready, b_ready);
            end
            tick();
            checks++;
            if (RegWrite !== 1'b0 || conflict_cnt !== 16'd0) begin
                failures++;
                $display("FAIL freeze_hold[%0d] got RegWrite=%b cnt=%0d exp 0/0", i, RegWrite, conflict_cnt);
            end
        end
        freeze = 1'b0;
        #2;
        checks++;
`ifdef WB_FIXED_PRIO_EN
        if (observed_grant() !== 2) begin
`else
        if (observed_grant() !== 1) begin
`endif
            failures++;
            $display("FAIL freeze_release_grant got a=%b b=%b", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 16'd1) begin
            failures++;
            $display("FAIL freeze_release_cnt got=%0d exp=1", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'h1;
        b_valid = 1'b1; b_reg = 5'd11; b_data = 32'h2;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (s_conflict_cnt !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                failures++;
                $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, s_conflict_cnt, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        checks++;
        if (conflict_cnt !== 16'd20) begin
            failures++;
            $display("FAIL sat_wide_cnt got=%0d exp=20", conflict_cnt);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            if (!a_valid || last_grant == 1) begin
                a_valid = $urandom_range(0, 1);
                a_reg   = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || last_grant == 2) begin
                b_valid = $urandom_range(0, 1);
                b_reg   = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            #2;
            g = exp_grant();
            checks++;
            if (observed_grant() !== g) begin
                failures++;
                $display("FAIL rand_grant[%0d] got a=%b b=%b exp=%0d", i, a_ready, b_ready, g);
            end
            tick();
            checks++;
            if (RegWrite !== m_rw || WriteReg !== m_wreg || WriteData !== m_wdata) begin
                failures++;
                $display("FAIL rand_write[%0d] got %b/%0d/%h exp %b/%0d/%h",
                         i, RegWrite, WriteReg, WriteData, m_rw, m_wreg, m_wdata);
            end
            checks++;
            if (conflict_cnt !== 16'(m_cnt) || s_conflict_cnt !== 4'(m_cnt_s)) begin
                failures++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d",
                         i, conflict_cnt, s_conflict_cnt, m_cnt, m_cnt_s);
            end
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; freeze = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0; failures = 0;
        m_last = 2; m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_cnt = 0; m_cnt_s = 0; last_grant = 0;
        rst = 1'b1; freeze = 1'b0;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        #1;
        test_reset();
        test_a_only();
        test_back_to_back();
        test_drop_r0();
        test_freeze();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates two writeback requesters for the single RegisterFile write port:
  - A: the ALU result path.
  - B: the load/memory result path.
- Uses a valid/ready handshake on each requester and drives a registered write request (RegWrite, WriteReg, WriteData).
- Sits between the execute/memory stages and the RegisterFile write port. The RegisterFile samples on the posedge of the same clock.

Parameters:
- DW, 32, data width of WriteData and requester data.
- AW, 5, register address width.
- DROP_R0, 1, when 1, a write to register 0 is accepted but never issued to the RegisterFile.
- CW, 16, width of the conflict counter.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous reset, active-high.
- freeze  input  1  pipeline freeze; no grants while high.
- a_valid  input  1  requester A has a write.
- a_reg  input  AW  requester A destination register.
- a_data  input  DW  requester A write data.
- a_ready  output  1  combinational grant to A.
- b_valid  input  1  requester B has a write.
- b_reg  input  AW  requester B destination register.
- b_data  input  DW  requester B write data.
- b_ready  output  1  combinational grant to B.
- RegWrite  output  1  registered write enable to the RegisterFile.
- WriteReg  output  AW  registered write address.
- WriteData  output  DW  registered write data.
- conflict_cnt  output  CW  count of cycles where both requesters were valid and not frozen.

Behaviour:
- Reset: synchronous, active-high. On the rst edge:
  - RegWrite=0, WriteReg=0, WriteData=0, conflict_cnt=0.
  - Round-robin pointer last=B, so A wins the first conflict.
  - rst overrides every other input.
  - With rst high, a_ready=b_ready=0 combinationally.
- Grant logic (combinational, freeze=0, rst=0):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester not equal to last.
  - At most one ready is high in any cycle.
  - freeze=1 -> both readies 0.
  - Ready may depend on valid. Requesters must hold valid, reg and data stable until accepted.
- Accept = valid & ready, at most one per cycle. On the accept edge:
  - last <= the granted requester. last is unchanged when there is no accept.
  - WriteReg <= granted reg.
  - WriteData <= granted data.
  - RegWrite <= 1, except when DROP_R0=1 and reg==0, in which case RegWrite <= 0 and the accept still completes.
- No accept in a cycle -> next cycle RegWrite=0. WriteReg and WriteData hold their last value.
- Latency:
  - Accept at edge T -> RegWrite high in the cycle after T.
  - The RegisterFile writes at edge T+1.
  - Read data is visible combinationally after T+1.
  - Throughput is one write per cycle.
- Back-to-back conflicts strictly alternate A,B,A,B while both stay valid.
- Same register on both requesters: no merging. Both writes are issued in grant order, so the later grant's data persists.
- conflict_cnt: increments on each cycle where a_valid & b_valid & ~freeze & ~rst. It saturates at all-ones and does not wrap.
- freeze asserted while RegWrite=1: the already-registered write still issues. Only new grants are blocked.
- rst mid-operation: a pending registered write is discarded (RegWrite=0 the next cycle) and the handshake state is lost. Requesters keep valid asserted and are re-arbitrated after reset.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined:
  - B (load path) always wins conflicts.
  - The last pointer is not implemented.
  - A is granted only when b_valid=0.
  - conflict_cnt still counts.
- Undefined: round-robin as specified above.

Test Plan:
- rst=1 for 2 cycles with a_valid=1, a_reg=1 -> a_ready=0, RegWrite=0, conflict_cnt=0. After rst drops, A is granted in the first cycle and RegWrite=1, WriteReg=1 in the next.
- A only, a_reg=3, a_data=0x87654321 -> a_ready=1 same cycle. RegWrite=1, WriteReg=3, WriteData=0x87654321 the next cycle. RegisterFile reg 3 reads 0x87654321 after the following edge.
- Both valid for 4 cycles, A reg 1 / 0x12345678, B reg 2 / 0x1234abcd, each dropping valid after acceptance and re-raising it with the same reg and data the next cycle:
  - Grant order is A,B,A,B.
  - conflict_cnt=4.
  - With WB_FIXED_PRIO_EN, B is granted every cycle and A never.
- A valid with a_reg=0, DROP_R0=1 -> a_ready=1, RegWrite stays 0, reg 0 unchanged. The next grant is B if both are valid.
- freeze=1 with both valid for 3 cycles -> both readies 0, RegWrite=0, conflict_cnt unchanged. After freeze drops, A is granted.
- Force the counter near saturation (CW=4 build, 20 conflict cycles) -> conflict_cnt=15 and holds at 15.
